case_4_sdiv_26s_12s_14_seq: RTL and testbench
=============================================

# case_4_sdiv_26s_12s_14_seq

Sequential signed divider that undoes the scaling done by the team's 14s×12s→26s multiplier cores. It takes a 26-bit signed dividend and a 12-bit signed divisor and returns a 14-bit saturated quotient and a 12-bit remainder. It uses a radix-2 restoring iteration, one quotient bit per clock. It sits in the HLS datapath after the multiply stage and uses a valid/ready handshake on both sides.

## Interface

**Parameters**
- `DIVIDEND_WIDTH`, 26, dividend width (signed).
- `DIVISOR_WIDTH`, 12, divisor and remainder width (signed).
- `QUOTIENT_WIDTH`, 14, quotient width (signed, saturated).

**Ports**
- `ap_clk`  in  1  single clock; all state updates on the rising edge.
- `ap_rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands (high only in IDLE).
- `din0`  in  DIVIDEND_WIDTH  signed dividend.
- `din1`  in  DIVISOR_WIDTH  signed divisor.
- `out_valid`  out  1  result valid, held until consumed.
- `out_ready`  in  1  consumer accepts result.
- `quot`  out  QUOTIENT_WIDTH  signed quotient, truncated toward zero, then saturated.
- `rem`  out  DIVISOR_WIDTH  signed remainder; takes the sign of the dividend.
- `dbz`  out  1  divisor was zero.
- `ovf`  out  1  quotient saturated (excluding the divide-by-zero case).

## Operation

**States:** IDLE → CALC → FIX → DONE → IDLE.

**IDLE**
- `in_ready` = 1.
- On `in_valid && in_ready`, latch:
  - sign of the dividend and sign of the divisor;
  - |din0| as a DIVIDEND_WIDTH-bit unsigned value;
  - |din1| as a DIVISOR_WIDTH-bit unsigned value.
- Clear the partial remainder and the iteration counter, then go to CALC.
- Magnitude edge case: |−2^25| = 2^25 and |−2^11| = 2^11 must be represented correctly (unsigned magnitude, no overflow).

**CALC** (exactly DIVIDEND_WIDTH cycles)
- Each cycle: shift the partial remainder left and bring in the next dividend bit, MSB first.
- Trial-subtract the divisor magnitude.
- If the result is ≥ 0, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
- Partial remainder width is DIVISOR_WIDTH+1 bits unsigned.
- The counter runs 0..DIVIDEND_WIDTH−1. After the last iteration, go to FIX.
- A zero divisor still runs the full iteration count, so latency is data-independent.

**FIX** (1 cycle)
- Quotient sign = sign(din0) XOR sign(din1). Negate the magnitude quotient when the sign is negative (full 26-bit result).
- Saturate to [−2^(QW−1), 2^(QW−1)−1] = [−8192, 8191]; set `ovf` if clipped.
- Remainder = magnitude remainder, negated when the dividend is negative. It always fits in DIVISOR_WIDTH bits.
- Divisor zero: `quot` = 8191 if din0 ≥ 0, else −8192; `rem` = 0; `dbz` = 1; `ovf` = 0.
- Register `quot`/`rem`/`dbz`/`ovf`, assert `out_valid`, go to DONE.

**DONE**
- Hold the outputs stable and keep `out_valid` high until `out_ready` is seen.
- On `out_valid && out_ready`: deassert `out_valid` and go to IDLE.

**Input and reset rules**
- Operands presented while busy are ignored (`in_ready` = 0). `in_valid` has no effect outside IDLE.
- Reset at any time, including mid-CALC, aborts the operation immediately and asynchronously. No partial result is emitted.
- Reset values: state = IDLE, `in_ready` = 1 once reset is released, `out_valid` = 0, `quot` = 0, `rem` = 0, `dbz` = 0, `ovf` = 0, counter = 0.

## Timing

- **Accept latency:** operands are accepted on edge E0. `out_valid` rises after edge E0+DIVIDEND_WIDTH+1 (E27 at default parameters), for every operand value.
- **Consume:** result consumed on edge Ec. `out_valid` = 0 and `in_ready` = 1 after Ec.
- **No bypass:** a new accept is possible on edge Ec+1 at the earliest; there is no same-cycle turnaround.
- **Throughput:** one result per DIVIDEND_WIDTH+3 = 29 cycles with `out_ready` tied high.
- **Backpressure:** `out_ready` low holds DONE indefinitely with the outputs unchanged.
- **Registered outputs:** `in_ready` decodes the state register only; `quot`/`rem`/flags come straight from registers. There is no combinational path from the inputs to any output.

## Test plan

1. **Positive / positive:** din0 = 1000, din1 = 7 → `quot` = 142, `rem` = 6, `dbz` = 0, `ovf` = 0. `out_valid` first high after the 27th edge following accept.
2. **Sign combinations:**
   - −1000/7 → `quot` = −142, `rem` = −6.
   - 1000/−7 → `quot` = −142, `rem` = 6.
   - −1000/−7 → `quot` = 142, `rem` = −6.
3. **Saturation:**
   - 33554431/1 → `quot` = 8191, `ovf` = 1, `rem` = 0.
   - −33554432/−1 → `quot` = 8191, `ovf` = 1.
   - −33554432/2047 → `quot` = −8192, `ovf` = 1.
   - 8191/1 → `quot` = 8191, `ovf` = 0.
4. **Divide by zero:**
   - 5/0 → `quot` = 8191, `rem` = 0, `dbz` = 1, `ovf` = 0.
   - −5/0 → `quot` = −8192, `dbz` = 1. Latency is unchanged (27).
5. **Backpressure and busy inputs:**
   - Hold `out_ready` = 0 for 10 cycles after `out_valid` → outputs stable and `in_ready` = 0 throughout.
   - Drive `in_valid` with other operands during CALC → the result is unaffected and no extra result is produced.
6. **Reset mid-operation:** assert `ap_rst_n` = 0 at CALC iteration 10 → `out_valid` = 0 and all outputs = 0 immediately (no clock edge needed). After release, 1000/7 completes normally with `quot` = 142.

Source files
------------

// File: rtl/case_4_sdiv_26s_12s_14_seq.sv
// Sequential signed divider (26s / 12s -> 14s saturated quotient, 12s remainder).
// Radix-2 restoring iteration, one quotient bit per clock, valid/ready on both sides.
module case_4_sdiv_26s_12s_14_seq #(
  parameter int DIVIDEND_WIDTH = 26,
  parameter int DIVISOR_WIDTH  = 12,
  parameter int QUOTIENT_WIDTH = 14
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] din0,
  input  logic signed [DIVISOR_WIDTH-1:0]  din1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [QUOTIENT_WIDTH-1:0] quot,
  output logic signed [DIVISOR_WIDTH-1:0]  rem,
  output logic                             dbz,
  output logic                             ovf
);

  localparam int NW = DIVIDEND_WIDTH;
  localparam int DW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  localparam logic signed [NW:0] QMAX = (NW + 1)'(2 ** (QW - 1) - 1);
  localparam logic signed [NW:0] QMIN = ~QMAX;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            sign_n, sign_d;
  logic [NW-1:0]   acc;
  logic [DW-1:0]   dmag;
  logic [DW:0]     prem;
  logic [DW+1:0]   shifted, diff;
  logic            take;
  logic signed [NW:0] qmag_s, q_full;
  logic signed [DW:0] rmag_s, r_full;
  logic            unused_bits;

  function automatic logic clipped(input logic signed [NW:0] v);
    return (v > QMAX) || (v < QMIN);
  endfunction

  function automatic logic signed [QW-1:0] sat_q(input logic signed [NW:0] v);
    if (v > QMAX) return QMAX[QW-1:0];
    if (v < QMIN) return QMIN[QW-1:0];
    return v[QW-1:0];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Trial subtraction: borrow out of the extended difference means restore.
  assign shifted = {prem, acc[NW-1]};
  assign diff    = shifted - {2'b00, dmag};
  assign take    = ~diff[DW+1];

  // Sign fix-up; the magnitude remainder is below 2^11 so it fits after negation.
  assign qmag_s      = $signed({1'b0, acc});
  assign q_full      = (sign_n ^ sign_d) ? -qmag_s : qmag_s;
  assign rmag_s      = $signed(prem);
  assign r_full      = sign_n ? -rmag_s : rmag_s;
  assign unused_bits = r_full[DW];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CALC) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = CALC;
      CALC:    if (cnt == LAST)   state_nxt = FIX;
      FIX:                        state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Operand capture and iteration datapath
  always_ff @(posedge ap_clk) begin
    if (state == IDLE && in_valid) begin
      sign_n <= din0[NW-1];
      sign_d <= din1[DW-1];
      acc    <= din0[NW-1] ? -din0 : din0;
      dmag   <= din1[DW-1] ? -din1 : din1;
      prem   <= '0;
    end else if (state == CALC) begin
      acc  <= {acc[NW-2:0], take};
      prem <= take ? diff[DW:0] : shifted[DW:0];
    end
  end

  // Result registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      quot <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == FIX) begin
      if (dmag == '0) begin
        quot <= sign_n ? QMIN[QW-1:0] : QMAX[QW-1:0];
        rem  <= '0;
        dbz  <= 1'b1;
        ovf  <= 1'b0;
      end else begin
        quot <= sat_q(q_full);
        rem  <= r_full[DW-1:0];
        dbz  <= 1'b0;
        ovf  <= clipped(q_full);
      end
    end
  end

endmodule

// File: tb/tb_case_4_sdiv_26s_12s_14_seq.sv
// Randomized + directed bench for the sequential signed divider, checked against
// an arithmetic reference model and a scoreboard of accepted operations.
module tb_case_4_sdiv_26s_12s_14_seq;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [25:0] din0 = '0;
  logic signed [11:0] din1 = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [13:0] quot;
  logic signed [11:0] rem;
  logic               dbz, ovf;

  case_4_sdiv_26s_12s_14_seq dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .dbz(dbz), .ovf(ovf)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint q;
    longint r;
    bit     z;
    bit     o;
    int     e0;
  } exp_t;

  exp_t sb[$];
  int   nvec  = 0;
  int   nfail = 0;
  int   cyc   = 0;
  bit   seen  = 1'b0;

  always @(posedge ap_clk) cyc++;

  function automatic void check(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: plain integer division truncates toward zero, % takes the dividend's sign.
  function automatic void model(input longint a, input longint b,
                                output longint q, output longint r,
                                output bit z, output bit o);
    z = 1'b0;
    o = 1'b0;
    if (b == 0) begin
      z = 1'b1;
      r = 0;
      q = (a >= 0) ? 8191 : -8192;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 8191) begin
        q = 8191;
        o = 1'b1;
      end else if (q < -8192) begin
        q = -8192;
        o = 1'b1;
      end
    end
  endfunction

  // Scoreboard push on accept, compare on every cycle a result is presented.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (in_valid && in_ready) begin
        exp_t e;
        model(longint'(din0), longint'(din1), e.q, e.r, e.z, e.o);
        e.e0 = cyc + 1;
        sb.push_back(e);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_result", sb.size(), 1);
        end else begin
          if (!seen) begin
            check("latency", cyc - sb[0].e0, 27);
            seen = 1'b1;
          end
          check("quot", longint'(quot), sb[0].q);
          check("rem", longint'(rem), sb[0].r);
          check("dbz", dbz, sb[0].z);
          check("ovf", ovf, sb[0].o);
          check("in_ready_busy", in_ready, 0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_op(input longint a, input longint b, input int hold, input bit busy);
    int n;
    @(posedge ap_clk); #1;
    din0 = a[25:0];
    din1 = b[11:0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 60) check("accept_timeout", n, 0);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    if (busy) begin
      repeat (10) begin
        din0 = 26'($urandom);
        din1 = 12'($urandom);
        in_valid = 1'b1;
        @(posedge ap_clk); #1;
      end
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (n >= 60) check("result_timeout", n, 0);
    repeat (hold) begin
      @(posedge ap_clk); #1;
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pin(input longint a, input longint b, input longint eq, input longint er,
                     input bit ez, input bit eo);
    longint q, r;
    bit z, o;
    model(a, b, q, r, z, o);
    check("model_q", q, eq);
    check("model_r", r, er);
    check("model_dbz", z, ez);
    check("model_ovf", o, eo);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint a, b, q, r;
    int mode;

    pin(1000, 7, 142, 6, 0, 0);
    pin(-1000, 7, -142, -6, 0, 0);
    pin(1000, -7, -142, 6, 0, 0);
    pin(-1000, -7, 142, -6, 0, 0);
    pin(33554431, 1, 8191, 0, 0, 1);
    pin(-33554432, 2047, -8192, -8, 0, 1);
    pin(-5, 0, -8192, 0, 1, 0);

    #1 ap_rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_flags", {dbz, ovf}, 0);
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    do_op(1000, 7, 0, 0);
    do_op(-1000, 7, 0, 0);
    do_op(1000, -7, 0, 0);
    do_op(-1000, -7, 0, 0);
    do_op(33554431, 1, 0, 0);
    do_op(-33554432, -1, 0, 0);
    do_op(-33554432, 2047, 0, 0);
    do_op(8191, 1, 0, 0);
    do_op(-8192, 1, 0, 0);
    do_op(-33554432, -2048, 0, 0);
    do_op(5, 0, 0, 0);
    do_op(-5, 0, 0, 0);
    do_op(1000, 7, 10, 0);
    do_op(-123456, 37, 0, 1);

    // Abort mid-iteration: outputs must clear without a clock edge.
    @(posedge ap_clk); #1;
    din0 = 26'sd1000;
    din1 = 12'sd7;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    #1 ap_rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_quot", quot, 0);
    check("abort_rem", rem, 0);
    check("abort_flags", {dbz, ovf}, 0);
    check("abort_in_ready", in_ready, 1);
    sb.delete();
    seen = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    do_op(1000, 7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      mode = int'($urandom_range(0, 3));
      b = longint'($urandom_range(0, 4095)) - 2048;
      if (mode == 3) b = 0;
      if (mode == 0) begin
        a = longint'($urandom_range(0, 67108863)) - 33554432;
      end else begin
        q = longint'($urandom_range(0, 16383)) - 8192;
        r = (b == 0) ? 0 : longint'($urandom % ((b < 0) ? -b : b));
        if ($urandom_range(0, 1) == 1) r = -r;
        a = q * b + r;
      end
      do_op(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (40) @(posedge ap_clk);
    check("pending_results", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
